text_cursor: RTL
================

Name: text_cursor

Overview:
Text-mode cursor overlay stage that consumes the blink phase signal from the blink generator and produces a per-pixel cursor mask for the pixel mixer. It holds a CPU-writable cursor position, shape and mode, and commits them at frame boundaries so the cursor never tears. A position move forces the cursor solid for a configurable number of frames before blinking resumes.

Parameters:
COLS, 80, text columns; col port width = $clog2(COLS)
ROWS, 30, text rows; row port width = $clog2(ROWS)
CHAR_HEIGHT, 16, scanlines per glyph; scanline width = $clog2(CHAR_HEIGHT)
HOLD_FRAMES, 30, frames the cursor stays solid after a move (0 = no hold)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
blinking  in  1  blink phase from blink generator (1 = on phase)
frame_start  in  1  one-cycle pulse at the first cycle of each frame
px_valid  in  1  current cycle carries a visible pixel
col  in  7  text column of the current pixel
row  in  5  text row of the current pixel
scanline  in  4  scanline within glyph of the current pixel
wr_en  in  1  register write strobe
wr_addr  in  2  0 = column, 1 = row, 2 = shape {end[7:4], start[3:0]}, 3 = mode[1:0]
wr_data  in  8  write data
cursor_px  out  1  cursor mask for the pixel presented two cycles earlier
cursor_visible  out  1  frame-latched visibility flag

Behaviour:
- Clock is clk; reset is synchronous and active-high. Every register is cleared or initialised on the clk edge where reset = 1.
- Reset values: pending and active column 0, row 0, shape start 14, end 15, mode 2, hold counter 0, cursor_visible 0, cursor_px 0, all pipeline stages 0.
- Writes: when wr_en = 1, wr_data goes into the pending register at wr_addr on the same edge. Column and row take the low 7 and 5 bits. A write to address 0 or 1 also sets pending_moved.
- Commit: on frame_start, pending column, row, shape and mode are copied to the active registers.
  - If pending_moved is set, hold_cnt is loaded with HOLD_FRAMES and pending_moved is cleared.
  - Otherwise hold_cnt decrements when it is above 0.
  - A write in the same cycle as frame_start updates the pending register and re-sets pending_moved; that write is committed at the next frame_start.
- Visibility, evaluated only on frame_start and using the post-commit mode and hold state:
  - mode 0: visible = 0
  - mode 1: visible = 1
  - mode 2: visible = blinking OR hold_active
  - mode 3: visible = NOT blinking OR hold_active
  - hold_active means the hold count for this frame is nonzero.
  - cursor_visible holds this value for the whole frame; blinking is ignored between frame_start pulses.
- Pixel pipeline, latency 2:
  - Stage 1 registers hit = px_valid AND col == active column AND row == active row AND start <= scanline <= end.
  - Stage 2 registers cursor_px = stage-1 hit AND cursor_visible.
- Boundaries:
  - start > end: no scanline matches, so the cursor is never drawn.
  - Active column >= COLS or row >= ROWS: never matches, so the cursor is hidden and no error is raised.
  - px_valid = 0: cursor_px is 0 two cycles later.
  - HOLD_FRAMES = 0: a move has no effect on blinking.
- Reset mid-frame: outputs return to 0 and the pipeline is flushed. cursor_visible stays 0 until the next frame_start.

Decomposition:
- Shared package holds the register address constants (ADDR_COL, ADDR_ROW, ADDR_SHAPE, ADDR_MODE) and the mode encoding enum (MODE_OFF, MODE_STEADY, MODE_BLINK, MODE_BLINK_INV), used by the bus decoder and the bench.
- One natural sub-module, cursor_regs: pending/active register banks, commit, and hold counter.
- The two-stage pixel compare pipeline stays in the top level.

Test Plan:
- Reset, then feed pixels at col 0, row 0, scanlines 14 and 15 over two frames with blinking = 1 -> cursor_px = 1 exactly 2 cycles after each of those pixels; 0 at scanline 13; cursor_visible = 1 after the first frame_start.
- Write col = 5 and row = 3 mid-frame -> old position is still drawn until the next frame_start; the new position is drawn afterwards.
- Mode 2, HOLD_FRAMES = 3, move the cursor, then hold blinking = 0 -> cursor_visible = 1 for frames 1–3 after the commit and 0 from frame 4.
- Mode 0, 1 and 3 with blinking toggling per frame -> visible is constant 0, constant 1, and the inverse of blinking, respectively.
- Shape start = 8, end = 4 -> cursor_px never asserts; column 90 (>= COLS) -> never asserts.
- Write pulse coincident with frame_start, and reset asserted mid-frame -> the coincident write commits one frame later; after reset, outputs are 0 on the next edge and registers hold their reset values.

Source files
------------

// File: rtl/text_cursor_pkg.sv
// Shared constants for the text cursor: register map, mode encoding and reset shape.
package text_cursor_pkg;

  localparam logic [1:0] ADDR_COL   = 2'd0;
  localparam logic [1:0] ADDR_ROW   = 2'd1;
  localparam logic [1:0] ADDR_SHAPE = 2'd2;
  localparam logic [1:0] ADDR_MODE  = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_STEADY    = 2'd1,
    MODE_BLINK     = 2'd2,
    MODE_BLINK_INV = 2'd3
  } mode_e;

  localparam logic [3:0] RST_START = 4'd14;
  localparam logic [3:0] RST_END   = 4'd15;

  // A move-triggered hold forces the cursor solid in both blinking modes.
  function automatic logic vis_for_mode(mode_e mode, logic blink, logic hold_active);
    logic vis;
    unique case (mode)
      MODE_OFF:       vis = 1'b0;
      MODE_STEADY:    vis = 1'b1;
      MODE_BLINK:     vis = blink | hold_active;
      MODE_BLINK_INV: vis = ~blink | hold_active;
      default:        vis = 1'b0;
    endcase
    return vis;
  endfunction

endpackage

// File: rtl/text_cursor_regs.sv
// Pending/active cursor register banks with frame-boundary commit, move hold counter
// and the frame-latched visibility flag.
module cursor_regs
  import text_cursor_pkg::*;
#(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned HOLD_FRAMES = 30,
  localparam int unsigned CW = $clog2(COLS),
  localparam int unsigned RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          blinking,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [7:0]    wr_data,
  output logic [CW-1:0] act_col,
  output logic [RW-1:0] act_row,
  output logic [3:0]    act_start,
  output logic [3:0]    act_end,
  output logic          visible
);

  localparam int unsigned HW = $clog2(HOLD_FRAMES + 2);

  logic [CW-1:0] pend_col_q, pend_col_d, act_col_q, act_col_d;
  logic [RW-1:0] pend_row_q, pend_row_d, act_row_q, act_row_d;
  logic [3:0]    pend_start_q, pend_start_d, act_start_q, act_start_d;
  logic [3:0]    pend_end_q, pend_end_d, act_end_q, act_end_d;
  mode_e         pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
  logic          moved_q, moved_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          vis_q, vis_d;

  always_comb begin
    pend_col_d   = pend_col_q;
    pend_row_d   = pend_row_q;
    pend_start_d = pend_start_q;
    pend_end_d   = pend_end_q;
    pend_mode_d  = pend_mode_q;
    act_col_d    = act_col_q;
    act_row_d    = act_row_q;
    act_start_d  = act_start_q;
    act_end_d    = act_end_q;
    act_mode_d   = act_mode_q;
    moved_d      = moved_q;
    hold_d       = hold_q;
    vis_d        = vis_q;

    if (frame_start) begin
      act_col_d   = pend_col_q;
      act_row_d   = pend_row_q;
      act_start_d = pend_start_q;
      act_end_d   = pend_end_q;
      act_mode_d  = pend_mode_q;
      moved_d     = 1'b0;
      if (moved_q) begin
        hold_d = HW'(HOLD_FRAMES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end
      vis_d = vis_for_mode(pend_mode_q, blinking, hold_d != '0);
    end

    // A write on a commit cycle lands in pending and waits for the next frame.
    if (wr_en) begin
      unique case (wr_addr)
        ADDR_COL: begin
          pend_col_d = wr_data[CW-1:0];
          moved_d    = 1'b1;
        end
        ADDR_ROW: begin
          pend_row_d = wr_data[RW-1:0];
          moved_d    = 1'b1;
        end
        ADDR_SHAPE: begin
          pend_start_d = wr_data[3:0];
          pend_end_d   = wr_data[7:4];
        end
        default: pend_mode_d = mode_e'(wr_data[1:0]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_col_q   <= '0;
      pend_row_q   <= '0;
      pend_start_q <= RST_START;
      pend_end_q   <= RST_END;
      pend_mode_q  <= MODE_BLINK;
      act_col_q    <= '0;
      act_row_q    <= '0;
      act_start_q  <= RST_START;
      act_end_q    <= RST_END;
      act_mode_q   <= MODE_BLINK;
      moved_q      <= 1'b0;
      hold_q       <= '0;
      vis_q        <= 1'b0;
    end else begin
      pend_col_q   <= pend_col_d;
      pend_row_q   <= pend_row_d;
      pend_start_q <= pend_start_d;
      pend_end_q   <= pend_end_d;
      pend_mode_q  <= pend_mode_d;
      act_col_q    <= act_col_d;
      act_row_q    <= act_row_d;
      act_start_q  <= act_start_d;
      act_end_q    <= act_end_d;
      act_mode_q   <= act_mode_d;
      moved_q      <= moved_d;
      hold_q       <= hold_d;
      vis_q        <= vis_d;
    end
  end

  assign act_col   = act_col_q;
  assign act_row   = act_row_q;
  assign act_start = act_start_q;
  assign act_end   = act_end_q;
  assign visible   = vis_q;

endmodule

// File: rtl/text_cursor.sv
// Text-mode cursor overlay: frame-committed cursor registers plus a two-stage
// pixel compare pipeline producing the cursor mask.
module text_cursor
  import text_cursor_pkg::*;
#(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned CHAR_HEIGHT = 16,
  parameter int unsigned HOLD_FRAMES = 30,
  localparam int unsigned CW = $clog2(COLS),
  localparam int unsigned RW = $clog2(ROWS),
  localparam int unsigned SW = $clog2(CHAR_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blinking,
  input  logic          frame_start,
  input  logic          px_valid,
  input  logic [CW-1:0] col,
  input  logic [RW-1:0] row,
  input  logic [SW-1:0] scanline,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [7:0]    wr_data,
  output logic          cursor_px,
  output logic          cursor_visible
);

  logic [CW-1:0] act_col;
  logic [RW-1:0] act_row;
  logic [3:0]    act_start, act_end;
  logic          visible;

  cursor_regs #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .blinking    (blinking),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .act_col     (act_col),
    .act_row     (act_row),
    .act_start   (act_start),
    .act_end     (act_end),
    .visible     (visible)
  );

  logic [3:0] sl;
  logic       in_range;
  logic       hit_d, hit_q, px_q;

  assign sl = 4'(scanline);
  // Out-of-range positions are representable in the port widths and must never match.
  assign in_range = (32'(act_col) < COLS) && (32'(act_row) < ROWS);

  always_comb begin
    hit_d = px_valid && in_range && (col == act_col) && (row == act_row) &&
            (act_start <= sl) && (sl <= act_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      px_q  <= 1'b0;
    end else begin
      hit_q <= hit_d;
      px_q  <= hit_q & visible;
    end
  end

  assign cursor_px      = px_q;
  assign cursor_visible = visible;

endmodule
